// File: rtl/clk_recover.sv
// Period-measuring clock recovery: times sig_in rising edges in in_clk cycles, locks once the
// period is stable, and regenerates a 50% duty clock re-aligned to every input edge.
module clk_recover #(
    parameter int unsigned MIN_PERIOD = 4,
    parameter int unsigned MAX_PERIOD = 4096,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TOL        = 2,
    localparam int unsigned W         = $clog2(MAX_PERIOD + 2)
) (
    input  logic         in_clk,
    input  logic         rst,
    input  logic         sig_in,
    output logic         edge_stb,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         out_clk
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0]  CNT_SAT = W'(MAX_PERIOD + 1);
    localparam logic [W-1:0]  MIN_P   = W'(MIN_PERIOD);
    localparam logic [W-1:0]  MAX_P   = W'(MAX_PERIOD);
    localparam logic [W:0]    TOL_W   = (W+1)'(TOL);
    localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t         state_q, state_d;
    logic           s1_q, s2_q, s3_q;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   ref_q, ref_d;
    logic [MW-1:0]  match_q, match_d;
    logic           edge_stb_q;
    logic [W-1:0]   period_q, period_d;
    logic           pv_q, pv_d;
    logic           locked_q, locked_d;
    logic           out_q, out_d;
    logic [W-1:0]   hcnt_q, hcnt_d;

    logic           edge_c, in_range_c, close_c, timeout_c;
    logic [W:0]     diff_c;
    logic [W-1:0]   half_c;

    assign edge_c     = s2_q & ~s3_q;
    assign in_range_c = (cnt_q >= MIN_P) && (cnt_q <= MAX_P);
    assign diff_c     = (cnt_q >= ref_q) ? ({1'b0, cnt_q} - {1'b0, ref_q})
                                         : ({1'b0, ref_q} - {1'b0, cnt_q});
    assign close_c    = diff_c <= TOL_W;
    assign timeout_c  = !edge_c && (cnt_q == CNT_SAT);
    assign half_c     = ref_q >> 1;

    // State register and datapath registers
    always_ff @(posedge in_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= '0;
            ref_q      <= '0;
            match_q    <= '0;
            edge_stb_q <= 1'b0;
            period_q   <= '0;
            pv_q       <= 1'b0;
            locked_q   <= 1'b0;
            out_q      <= 1'b0;
            hcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= sig_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            cnt_q      <= cnt_d;
            ref_q      <= ref_d;
            match_q    <= match_d;
            edge_stb_q <= edge_c;
            period_q   <= period_d;
            pv_q       <= pv_d;
            locked_q   <= locked_d;
            out_q      <= out_d;
            hcnt_q     <= hcnt_d;
        end
    end

    // Next state: period counter, reference and consistency tracking
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        match_d = match_q;
        if (edge_c)                 cnt_d = W'(1);
        else if (cnt_q == CNT_SAT)  cnt_d = cnt_q;
        else                        cnt_d = cnt_q + W'(1);

        unique case (state_q)
            IDLE: begin
                if (edge_c) begin
                    state_d = MEASURE;
                    ref_d   = '0;
                    match_d = '0;
                end
            end
            MEASURE: begin
                if (edge_c) begin
                    if (!in_range_c) begin
                        ref_d   = '0;
                        match_d = '0;
                    end else begin
                        if (match_q == '0 || !close_c) begin
                            ref_d   = cnt_q;
                            match_d = MW'(1);
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                        if (match_d == LOCK_N) state_d = LOCKED;
                    end
                end else if (timeout_c) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (edge_c) begin
                    if (!(in_range_c && close_c)) begin
                        state_d = MEASURE;
                        ref_d   = in_range_c ? cnt_q : '0;
                        match_d = in_range_c ? MW'(1) : '0;
                    end
                end else if (timeout_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values; out_clk high phase restarts on every edge while locked
    always_comb begin
        pv_d     = edge_c && in_range_c && (state_q == MEASURE || state_q == LOCKED);
        period_d = pv_d ? cnt_q : period_q;
        locked_d = (state_q == LOCKED);
        out_d    = 1'b0;
        hcnt_d   = hcnt_q;
        if (state_q == LOCKED) begin
            if (edge_stb_q) begin
                out_d  = (half_c != '0);
                hcnt_d = W'(1);
            end else if (hcnt_q < half_c) begin
                out_d  = 1'b1;
                hcnt_d = hcnt_q + W'(1);
            end
        end else begin
            hcnt_d = '1;
        end
    end

    assign edge_stb     = edge_stb_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign out_clk      = out_q;

endmodule
